// File: rtl/mstream_unpack.sv
// mstream_unpack: unpacks 256-bit FIFO words into four 64-bit output beats,
// lane 0 (bits [63:0]) first. A hold register feeds the output while a spare
// register absorbs the next FIFO word, so back-to-back words stream without
// bubbles. At most one FIFO read is ever outstanding.
module mstream_unpack #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stream_en_i,
  output logic             stream_en_o,
  input  logic [255:0]     fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  output logic             fifo_rd_en,
  output logic [63:0]      DO,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] word_count,
  output logic             protocol_err
);

  logic [255:0] hold_q, spare_q;
  logic         hold_v, spare_v;
  logic [1:0]   lane;
  logic         rd_pending;

  logic [255:0] hold_n, spare_n;
  logic         hold_v_n, spare_v_n;
  logic [1:0]   lane_n;

  logic accept, release_hold, capture;

  assign accept       = hold_v && ready_in;
  assign release_hold = accept && (lane == 2'd3);
  assign capture      = fifo_valid && rd_pending;

  // Only fetch when a buffer slot is guaranteed free for the returning word.
  assign fifo_rd_en = stream_en_o && !fifo_empty && !rd_pending && !(hold_v && spare_v);

  assign valid_out = hold_v;
  assign DO        = hold_q[{lane, 6'd0} +: 64];

  // Buffer/lane next-state: a freed hold is refilled from spare first so FIFO
  // order is preserved; a captured word goes straight to hold when nothing
  // older is waiting.
  always_comb begin
    hold_n    = hold_q;
    hold_v_n  = hold_v;
    spare_n   = spare_q;
    spare_v_n = spare_v;
    lane_n    = lane;
    if (release_hold) begin
      lane_n = '0;
      if (spare_v) begin
        hold_n    = spare_q;
        spare_v_n = 1'b0;
        if (capture) begin
          spare_n   = fifo_dout;
          spare_v_n = 1'b1;
        end
      end else if (capture) begin
        hold_n = fifo_dout;
      end else begin
        hold_v_n = 1'b0;
      end
    end else begin
      if (accept) begin
        lane_n = lane + 2'd1;
      end
      if (capture) begin
        if (!hold_v) begin
          hold_n   = fifo_dout;
          hold_v_n = 1'b1;
        end else begin
          spare_n   = fifo_dout;
          spare_v_n = 1'b1;
        end
      end
    end
  end

  // Control state; reset wins over any fifo_valid arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v       <= 1'b0;
      spare_v      <= 1'b0;
      lane         <= '0;
      rd_pending   <= 1'b0;
      word_count   <= '0;
      protocol_err <= 1'b0;
      stream_en_o  <= 1'b0;
    end else begin
      hold_v      <= hold_v_n;
      spare_v     <= spare_v_n;
      lane        <= lane_n;
      stream_en_o <= stream_en_i;
      if (fifo_rd_en) begin
        rd_pending <= 1'b1;
      end else if (fifo_valid) begin
        rd_pending <= 1'b0;
      end
      if (fifo_valid && !rd_pending) begin
        protocol_err <= 1'b1;
      end
      if (accept) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  // Data registers carry no reset; their contents only matter under the valid bits.
  always_ff @(posedge clk) begin
    hold_q  <= hold_n;
    spare_q <= spare_n;
  end

endmodule

// File: tb/tb_mstream_unpack.sv
// Self-checking bench for mstream_unpack: a FIFO model feeds 256-bit words,
// every word the FIFO hands out queues its four 64-bit lanes as expected
// output, and a monitor pops and compares on each accepted beat.
module tb_mstream_unpack;

  logic         clk = 1'b0;
  logic         reset;
  logic         stream_en_i;
  logic         stream_en_o;
  logic [255:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_valid;
  logic         fifo_rd_en;
  logic [63:0]  DO;
  logic         valid_out;
  logic         ready_in;
  logic [15:0]  word_count;
  logic         protocol_err;

  mstream_unpack #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .stream_en_i (stream_en_i),
    .stream_en_o (stream_en_o),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_valid  (fifo_valid),
    .fifo_rd_en  (fifo_rd_en),
    .DO          (DO),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .word_count  (word_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] q[$];       // FIFO contents not yet read
  logic [63:0]  exp_q[$];   // expected output beats, in order
  logic         pend = 1'b0;
  logic [255:0] pend_word;
  logic         inject = 1'b0;
  int           cyc = 0;
  logic         lat_arm = 1'b0;
  int           rd_cyc = -1;
  int           vld_cyc = -1;
  int           run = 0;
  int           max_run = 0;
  logic         dis_armed = 1'b0;
  int           drop_cyc = 0;
  logic [15:0]  cnt_model = '0;
  logic         hold_chk = 1'b0;
  logic [63:0]  held_do;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] rword();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: data returns one cycle after the read strobe; each word read
  // enqueues its four lanes, low lane first.
  initial forever begin
    @(negedge clk);
    #1;
    if (inject) begin
      fifo_valid = 1'b1;
      fifo_dout  = rword();
      inject     = 1'b0;
    end else begin
      fifo_valid = pend;
      if (pend) fifo_dout = pend_word;
    end
    pend       = 1'b0;
    fifo_empty = (q.size() == 0);
    #1;
    if (!reset) begin
      if (fifo_valid) chk("single_outstanding", 64'(fifo_rd_en), 64'd0);
      if (dis_armed && cyc > drop_cyc) chk("no_rd_after_disable", 64'(fifo_rd_en), 64'd0);
      if (fifo_rd_en) begin
        chk("rd_while_empty", 64'(fifo_empty), 64'd0);
        if (q.size() > 0) begin
          pend_word = q.pop_front();
          pend      = 1'b1;
          for (int l = 0; l < 4; l++) exp_q.push_back(pend_word[64*l +: 64]);
          if (lat_arm && rd_cyc < 0) rd_cyc = cyc;
        end
      end
    end
  end

  // Monitor: compares every accepted beat and checks stability under backpressure.
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    #3;
    if (reset) begin
      hold_chk = 1'b0;
      run      = 0;
    end else begin
      if (hold_chk) begin
        chk("stall_valid_held", 64'(valid_out), 64'd1);
        chk("stall_do_held", DO, held_do);
        hold_chk = 1'b0;
      end
      if (valid_out) begin
        run++;
        if (run > max_run) max_run = run;
        if (lat_arm && vld_cyc < 0) vld_cyc = cyc;
        if (ready_in) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %0h expected none", DO);
          end else begin
            e = exp_q.pop_front();
            chk("do_data", DO, e);
          end
          chk("word_count_run", 64'(word_count), 64'(cnt_model));
          cnt_model = cnt_model + 16'd1;
        end else begin
          hold_chk = 1'b1;
          held_do  = DO;
        end
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_valid(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string name, input logic allow_q);
    logic ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pend && !valid_out && (allow_q || q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [255:0] w;
    logic [63:0]  do0;
    logic [15:0]  wc;
    reset       = 1'b1;
    stream_en_i = 1'b0;
    ready_in    = 1'b0;
    fifo_valid  = 1'b0;
    fifo_empty  = 1'b1;
    fifo_dout   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);
    chk("rst_stream_en_o", 64'(stream_en_o), 64'd0);

    // Lane order and first-word latency
    stream_en_i = 1'b1;
    ready_in    = 1'b1;
    @(negedge clk);
    lat_arm = 1'b1;
    w = {64'h4, 64'h3, 64'h2, 64'h1};
    q.push_back(w);
    wait_idle("lane_order_idle", 1'b0);
    chk("first_valid_latency", 64'(vld_cyc - rd_cyc), 64'd2);
    chk("lane_order_count", 64'(word_count), 64'd4);
    lat_arm = 1'b0;

    // Backpressure while lane 1 is shown
    q.push_back(w);
    wait_valid("bp_wait_valid");
    @(negedge clk);
    ready_in = 1'b0;
    wc = word_count;
    chk("bp_lane1", DO, 64'h2);
    repeat (3) @(negedge clk);
    chk("bp_count_frozen", 64'(word_count), 64'(wc));
    chk("bp_do_held", DO, 64'h2);
    ready_in = 1'b1;
    wait_idle("bp_idle", 1'b0);
    chk("bp_count", 64'(word_count), 64'd8);

    // Streaming three words without bubbles
    max_run = 0;
    for (int i = 0; i < 3; i++) q.push_back(rword());
    wait_idle("stream_idle", 1'b0);
    chk("stream_no_gap", 64'(max_run), 64'd12);
    chk("stream_count", 64'(word_count), 64'd20);

    // Disable during word 1 of 3
    for (int i = 0; i < 3; i++) q.push_back(rword());
    wait_valid("dis_wait_valid");
    stream_en_i = 1'b0;
    drop_cyc    = cyc;
    dis_armed   = 1'b1;
    wait_idle("dis_idle", 1'b1);
    chk("dis_left_in_fifo", 64'(q.size()), 64'd1);
    chk("dis_count", 64'(word_count), 64'd28);
    dis_armed = 1'b0;
    q.delete();
    stream_en_i = 1'b1;

    // Spurious fifo_valid with no read outstanding
    ready_in = 1'b0;
    q.push_back(rword());
    wait_valid("sp_wait_valid");
    repeat (3) @(negedge clk);
    chk("sp_err_before", 64'(protocol_err), 64'd0);
    do0 = DO;
    wc  = word_count;
    inject = 1'b1;
    repeat (2) @(negedge clk);
    chk("sp_err_set", 64'(protocol_err), 64'd1);
    chk("sp_valid_kept", 64'(valid_out), 64'd1);
    chk("sp_do_kept", DO, do0);
    chk("sp_count_kept", 64'(word_count), 64'(wc));
    repeat (3) @(negedge clk);
    chk("sp_err_sticky", 64'(protocol_err), 64'd1);
    ready_in = 1'b1;
    wait_idle("sp_idle", 1'b0);
    chk("sp_err_sticky_end", 64'(protocol_err), 64'd1);

    // Reset while lane 2 is shown, with fifo_valid in the reset cycle
    q.push_back(rword());
    wait_valid("rst_wait_valid");
    repeat (2) @(negedge clk);
    chk("rst_mid_lane2", DO, exp_q[0]);
    ready_in = 1'b0;
    reset    = 1'b1;
    inject   = 1'b1;
    exp_q.delete();
    cnt_model = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_valid", 64'(valid_out), 64'd0);
    chk("rst_mid_count", 64'(word_count), 64'd0);
    chk("rst_mid_err", 64'(protocol_err), 64'd0);
    chk("rst_mid_rd_en", 64'(fifo_rd_en), 64'd0);
    ready_in = 1'b1;
    q.push_back(rword());
    wait_idle("rst_mid_idle", 1'b0);
    chk("rst_mid_recount", 64'(word_count), 64'd4);

    // Randomized traffic: random ready, stream enable and FIFO fill
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ready_in    = ($urandom_range(0, 3) != 0);
      stream_en_i = ($urandom_range(0, 15) != 0);
      if (q.size() < 3 && $urandom_range(0, 1) == 1) q.push_back(rword());
    end
    stream_en_i = 1'b1;
    ready_in    = 1'b1;
    wait_idle("rand_idle", 1'b0);
    chk("rand_count", 64'(word_count), 64'(cnt_model));
    chk("rand_err", 64'(protocol_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mstream_unpack.md
MSTREAM_UNPACK -- requirements
Module: mstream_unpack

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the emitted-word counter.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: stream_en_i  in  1  enables fetching from the input FIFO.
REQ-005 SHALL have port: stream_en_o  out  1  stream_en_i registered once.
REQ-006 SHALL have port: fifo_dout  in  256  input-FIFO read data.
REQ-007 SHALL have port: fifo_empty  in  1  input FIFO empty.
REQ-008 SHALL have port: fifo_valid  in  1  fifo_dout valid; returned one cycle after fifo_rd_en.
REQ-009 SHALL have port: fifo_rd_en  out  1  input-FIFO read strobe.
REQ-010 SHALL have port: DO  out  64  output word.
REQ-011 SHALL have port: valid_out  out  1  DO valid.
REQ-012 SHALL have port: ready_in  in  1  downstream accepts DO; accept = valid_out && ready_in.
REQ-013 SHALL have port: word_count  out  CNT_W  count of accepted 64-bit words.
REQ-014 SHALL have port: protocol_err  out  1  sticky flag for unexpected fifo_valid.

Function
REQ-015 SHALL hold two 256-bit registers, hold and spare, each with a valid bit, plus a 2-bit lane index and a read-pending bit.
REQ-016 SHALL drive fifo_rd_en = stream_en_o && !fifo_empty && !rd_pending && (hold_v + spare_v < 2), all from registered state except fifo_empty.
REQ-017 SHALL never assert fifo_rd_en while fifo_empty = 1.
REQ-018 SHALL set rd_pending on fifo_rd_en and clear it on fifo_valid.
REQ-019 SHALL, on fifo_valid with rd_pending = 1, load fifo_dout into hold if hold is empty or freed this cycle with spare empty; otherwise load it into spare.
REQ-020 SHALL, on fifo_valid with rd_pending = 0, set protocol_err, discard the data and leave all other state unchanged.
REQ-021 SHALL drive valid_out = hold_v and DO = hold[64*lane +: 64]: lane 0 = bits [63:0] first, lane 3 = bits [255:192] last.
REQ-022 SHALL keep DO and valid_out stable while valid_out && !ready_in.
REQ-023 SHALL, on accept with lane < 3, increment lane.
REQ-024 SHALL, on accept with lane = 3, reset lane to 0 and free hold.
REQ-025 SHALL, when hold is freed, refill it from spare if spare_v (clearing spare_v); otherwise from fifo_dout if fifo_valid arrives that cycle; otherwise clear hold_v.
REQ-026 SHALL increment word_count by 1 per accept, wrapping modulo 2^CNT_W.
REQ-027 SHALL present the first DO exactly 2 cycles after the first fifo_rd_en from an empty state.
REQ-028 SHALL sustain one accepted word per cycle, with no bubbles, while ready_in = 1 and the FIFO stays non-empty.
REQ-029 SHALL, when stream_en_i drops, stop issuing new reads from the next cycle on (following stream_en_o), still capture any pending read, and keep draining all buffered words.
REQ-030 SHALL be invariant to ready_in while valid_out = 0.

Reset
REQ-031 SHALL, while reset = 1, clear on the next edge: hold_v, spare_v, rd_pending, lane = 0, word_count = 0, protocol_err = 0, stream_en_o = 0; hence fifo_rd_en = 0 and valid_out = 0.
REQ-032 SHALL discard buffered data on reset mid-operation and ignore a fifo_valid arriving in the reset cycle (no protocol_err).
REQ-033 SHALL leave the DO value undefined-but-stable while valid_out = 0; verification checks DO only when valid_out = 1.

Verification
REQ-034 SHALL cover lane order: one FIFO word {64'h4,64'h3,64'h2,64'h1}, stream_en_i = 1, ready_in = 1 -> DO = 1,2,3,4 on 4 consecutive cycles, first valid_out 2 cycles after fifo_rd_en, word_count = 4.
REQ-035 SHALL cover backpressure: ready_in = 0 for 3 cycles while lane 1 is shown -> DO = 2 held for 3 cycles, word_count unchanged, then 2,3,4.
REQ-036 SHALL cover streaming: 3 FIFO words, ready_in = 1 -> 12 consecutive valid_out cycles with no gap, word_count = 12, never more than one read outstanding.
REQ-037 SHALL cover disable: stream_en_i deasserted during word 1 of 3 -> no fifo_rd_en from one cycle later, buffered words fully emitted, remaining word left in FIFO.
REQ-038 SHALL cover spurious fifo_valid with no read outstanding -> protocol_err = 1 and stays 1, DO/valid_out/word_count unchanged.
REQ-039 SHALL cover reset mid-word (lane 2) -> next cycle valid_out = 0, word_count = 0, lane restarts at 0 on the next fetched word.
